// File: rtl/gate_occupancy_ctrl_pkg.sv
// Shared types and constants for the gate occupancy controller.
package gate_occupancy_ctrl_pkg;

  // Direction-detect FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENT1  = 3'd1,
    ST_ENT2  = 3'd2,
    ST_ENT3  = 3'd3,
    ST_EXT1  = 3'd4,
    ST_EXT2  = 3'd5,
    ST_EXT3  = 3'd6,
    ST_ABORT = 3'd7
  } gate_state_e;

  // Synchronized sensor pair encodings, {a,b}
  localparam logic [1:0] CLEAR  = 2'b00;
  localparam logic [1:0] A_ONLY = 2'b10;
  localparam logic [1:0] B_ONLY = 2'b01;
  localparam logic [1:0] BOTH   = 2'b11;

endpackage

// File: rtl/gate_occupancy_ctrl_gate_dir_fsm.sv
// Sensor synchronizers plus the A/B overlap direction-detect FSM.
// Produces registered one-cycle enter/exit/sequence-error strobes.
module gate_dir_fsm
  import gate_occupancy_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sensor_a,
  input  logic i_sensor_b,
  output logic o_enter_pulse,
  output logic o_exit_pulse,
  output logic o_seq_error
);

  logic        r_a_meta, r_a_sync;
  logic        r_b_meta, r_b_sync;
  gate_state_e r_state;
  gate_state_e w_next;
  logic        w_enter, w_exit, w_err;
  logic        r_enter, r_exit, r_err;
  logic [1:0]  w_pair;

  // Two-flop synchronizers for the asynchronous beam inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= i_sensor_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= i_sensor_b;
      r_b_sync <= r_b_meta;
    end
  end

  assign w_pair = {r_a_sync, r_b_sync};

  // Next-state and strobe decode; unlisted pairs hold the current state
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        case (w_pair)
          A_ONLY:  w_next = ST_ENT1;
          B_ONLY:  w_next = ST_EXT1;
          BOTH:    begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_IDLE;
        endcase
      end
      ST_ENT1: begin
        case (w_pair)
          BOTH:    w_next = ST_ENT2;
          CLEAR:   w_next = ST_IDLE;
          B_ONLY:  begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_ENT1;
        endcase
      end
      ST_ENT2: begin
        case (w_pair)
          B_ONLY:  w_next = ST_ENT3;
          A_ONLY:  w_next = ST_ENT1;
          CLEAR:   begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_ENT2;
        endcase
      end
      ST_ENT3: begin
        case (w_pair)
          CLEAR:   begin w_next = ST_IDLE; w_enter = 1'b1; end
          BOTH:    w_next = ST_ENT2;
          A_ONLY:  begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_ENT3;
        endcase
      end
      ST_EXT1: begin
        case (w_pair)
          BOTH:    w_next = ST_EXT2;
          CLEAR:   w_next = ST_IDLE;
          A_ONLY:  begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_EXT1;
        endcase
      end
      ST_EXT2: begin
        case (w_pair)
          A_ONLY:  w_next = ST_EXT3;
          B_ONLY:  w_next = ST_EXT1;
          CLEAR:   begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_EXT2;
        endcase
      end
      ST_EXT3: begin
        case (w_pair)
          CLEAR:   begin w_next = ST_IDLE; w_exit = 1'b1; end
          BOTH:    w_next = ST_EXT2;
          B_ONLY:  begin w_next = ST_ABORT; w_err = 1'b1; end
          default: w_next = ST_EXT3;
        endcase
      end
      ST_ABORT: begin
        if (w_pair == CLEAR) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and registered strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_enter <= w_enter;
      r_exit  <= w_exit;
      r_err   <= w_err;
    end
  end

  assign o_enter_pulse = r_enter;
  assign o_exit_pulse  = r_exit;
  assign o_seq_error   = r_err;

endmodule

// File: rtl/gate_occupancy_ctrl.sv
// Gate occupancy controller: direction FSM driving a saturating
// occupancy counter with full/empty flags and a combined error strobe.
module gate_occupancy_ctrl
  import gate_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             error
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_enter, w_exit, w_seq_err;
  logic [CNT_W-1:0] r_occ;
  logic             r_reject;

  gate_dir_fsm u_dir (
    .i_clk         (clk),
    .i_rst_n       (reset),
    .i_sensor_a    (sensor_a),
    .i_sensor_b    (sensor_b),
    .o_enter_pulse (w_enter),
    .o_exit_pulse  (w_exit),
    .o_seq_error   (w_seq_err)
  );

  // Saturating counter; an event that would overflow/underflow is rejected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ    <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      if (w_enter) begin
        if (r_occ < CAP) r_occ <= r_occ + ONE;
        else             r_reject <= 1'b1;
      end else if (w_exit) begin
        if (r_occ != '0) r_occ <= r_occ - ONE;
        else             r_reject <= 1'b1;
      end
    end
  end

  assign occupancy   = r_occ;
  assign full        = (r_occ == CAP);
  assign empty       = (r_occ == '0);
  assign enter_pulse = w_enter;
  assign exit_pulse  = w_exit;
  assign error       = w_seq_err | r_reject;

endmodule

// File: tb/tb_gate_occupancy_ctrl.sv
// Scoreboard bench for gate_occupancy_ctrl (CAPACITY=4).
module tb_gate_occupancy_ctrl;

  localparam int CAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_a, sensor_b;
  logic [4:0] occupancy;
  logic       full, empty, enter_pulse, exit_pulse, error;

  gate_occupancy_ctrl #(.CAPACITY(CAP), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;     // {enter, exit, error}
    bit         chk_occ;
    int         occ;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_occ = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] kind, input bit c, input int o);
    exp_t e;
    e.kind = kind; e.chk_occ = c; e.occ = o;
    return e;
  endfunction

  task automatic hold(input logic [1:0] v, input int n = 3);
    {sensor_a, sensor_b} = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_entry();
    if (exp_occ < CAP) begin
      exp_occ++;
      q.push_back(mk(3'b100, 1'b1, exp_occ));
    end else begin
      q.push_back(mk(3'b100, 1'b1, exp_occ));
      q.push_back(mk(3'b001, 1'b0, 0));
    end
    hold(2'b10); hold(2'b11); hold(2'b01); hold(2'b00);
  endtask

  task automatic do_exit();
    if (exp_occ > 0) begin
      exp_occ--;
      q.push_back(mk(3'b010, 1'b1, exp_occ));
    end else begin
      q.push_back(mk(3'b010, 1'b1, exp_occ));
      q.push_back(mk(3'b001, 1'b0, 0));
    end
    hold(2'b01); hold(2'b11); hold(2'b10); hold(2'b00);
  endtask

  // Monitor: checks occupancy/flags after each counted event and pops
  // the expected event whenever a strobe appears.
  initial begin
    bit   pend = 1'b0;
    int   pend_occ = 0;
    exp_t it;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("occupancy", int'(occupancy), pend_occ);
        chk("full", int'(full), int'(pend_occ == CAP));
        chk("empty", int'(empty), int'(pend_occ == 0));
        pend = 1'b0;
      end
      if (enter_pulse || exit_pulse || error) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'({enter_pulse, exit_pulse, error}), 0);
        end else begin
          it = q.pop_front();
          chk("event_kind", int'({enter_pulse, exit_pulse, error}), int'(it.kind));
          if (it.chk_occ) begin
            pend = 1'b1;
            pend_occ = it.occ;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    // Reset held with sensors toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {sensor_a, sensor_b} = 2'(i + 1);
      #1;
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_pulses", int'({enter_pulse, exit_pulse, error}), 0);
    end
    @(negedge clk);
    {sensor_a, sensor_b} = 2'b00;
    reset = 1'b1;
    hold(2'b00, 5);

    // Three entries, one exit
    do_entry(); do_entry(); do_entry();
    do_exit();

    // Back-out: no event expected
    hold(2'b10); hold(2'b11); hold(2'b10); hold(2'b00);

    // Illegal: IDLE straight to BOTH, then an entry shape without clearing
    q.push_back(mk(3'b001, 1'b0, 0));
    hold(2'b11); hold(2'b10); hold(2'b11); hold(2'b01);
    hold(2'b00);
    do_entry();

    // Saturation at CAPACITY, then drain past zero
    do_entry();
    do_entry();
    for (int i = 0; i < 5; i++) do_exit();

    // Reset mid-sequence while in ENT2 with occupancy 2
    do_entry(); do_entry();
    hold(2'b10); hold(2'b11);
    #2 reset = 1'b0;
    #1;
    chk("midrst_occ", int'(occupancy), 0);
    chk("midrst_empty", int'(empty), 1);
    exp_occ = 0;
    repeat (2) @(negedge clk);
    q.push_back(mk(3'b001, 1'b0, 0));
    reset = 1'b1;
    hold(2'b11, 5);
    hold(2'b00);
    do_entry();

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_occupancy_ctrl.md
# gate_occupancy_ctrl

Sequences the lab's occupancy up/down counter from a pair of beam sensors at a single lot gate. A direction-detect state machine turns the sensors' A/B overlap sequence into enter/exit events. The block keeps a saturating occupancy count from those events and drives full/empty status for the display and lockout logic.

## Interface
- CAPACITY, 16: maximum occupancy; legal range 1 to 2^CNT_W−1.
- CNT_W, 5: occupancy width.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- sensor_a  in  1  outer beam, 1 = blocked; asynchronous to clk.
- sensor_b  in  1  inner beam, 1 = blocked; asynchronous to clk.
- occupancy  out  CNT_W  current count, unsigned.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- enter_pulse  out  1  one-cycle strobe per completed entry.
- exit_pulse  out  1  one-cycle strobe per completed exit.
- error  out  1  one-cycle strobe on an illegal sensor sequence or a rejected count.

## Operation
- Each sensor passes through a 2-flop synchronizer. The FSM sees only the synchronized pair {a,b}.
- FSM states: IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, ABORT.
- IDLE: 10→ENT1, 01→EXT1, 11→ABORT with error; 00 stays.
- ENT1: 11→ENT2, 00→IDLE (car backed out, no count), 01→ABORT with error.
- ENT2: 01→ENT3, 10→ENT1, 00→ABORT with error.
- ENT3: 00→IDLE with enter_pulse, 11→ENT2, 10→ABORT with error.
- EXT1/EXT2/EXT3 mirror the ENT states with a and b swapped. EXT3 to 00 gives exit_pulse.
- ABORT: stays until 00, then goes to IDLE. No pulses are generated in ABORT.
- Counter:
  - enter_pulse with occupancy < CAPACITY: +1.
  - enter_pulse at CAPACITY: hold the count and pulse error.
  - exit_pulse with occupancy > 0: −1.
  - exit_pulse at 0: hold the count and pulse error.
- enter_pulse and exit_pulse are mutually exclusive by construction. There is no simultaneous-event case.
- No wrap-around is permitted in either direction.
- Reset values: FSM=IDLE, synchronizers=0, occupancy=0, empty=1, full=0, all pulses=0.
- Reset asserted mid-sequence discards the partial event. After release, the FSM starts from IDLE using the current sensor values.
- A car that stays blocked holds the FSM in its current state indefinitely. There is no timeout.

## Timing
- Sensor edge before clock edge N → synchronized value at edge N+1 → FSM transition at edge N+2.
- enter_pulse, exit_pulse and sequence-error are registered. They are high for exactly the one cycle following edge N+2.
- occupancy updates at edge N+3.
- full and empty are decoded from the occupancy register and change in the same cycle as occupancy.
- A count-reject error is high for the one cycle following edge N+3.
- Minimum input dwell: each sensor state must persist ≥ 2 clocks to be seen reliably. Shorter glitches may be skipped.
- Back-to-back cars: a new ENT1 may begin on the cycle after IDLE is re-entered.

## Structure
- Shared package holds:
  - the state enum for the 8 FSM states;
  - the sensor-pair encodings as named constants (CLEAR=00, A_ONLY=10, B_ONLY=01, BOTH=11).
- Sub-module gate_dir_fsm:
  - contains the synchronizers and the FSM;
  - outputs enter_pulse, exit_pulse and seq_error.
- Top level contains the saturating counter, the flags and the OR of the error sources.

## Test plan
- Reset: hold reset=0 for 3 clocks with sensors toggling → occupancy=0, empty=1, no pulses. Release reset → state remains IDLE.
- Three entries (00,10,11,01,00, each held 3 clocks) → three enter_pulses, occupancy=3. One exit sequence (00,01,11,10,00) → occupancy=2.
- Back-out: 00,10,11,10,00 → no pulse, no error, occupancy unchanged.
- Illegal sequence: IDLE then 11 directly → error for 1 cycle, FSM in ABORT. Then a full entry sequence without passing 00 → no count. Then 00 followed by a legal entry → +1.
- Saturation: with CAPACITY=4, run 5 entries → occupancy=4, full=1, error on the 5th. Run 5 exits from 4 → occupancy=0, empty=1, error on the 5th.
- Reset mid-operation: assert reset while in ENT2 with occupancy=2 → immediate occupancy=0 and IDLE. Sensors still 11 after release → ABORT with error.
